// File: rtl/mul_cell_share_ctrl_if.sv
// Requester-side channel of the shared multiplier: request handshake with operands and signs,
// plus the valid/ready response carrying the 64-bit product.
interface mul_cell_share_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        src1_signed;
  logic        src2_signed;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_product;

  modport master (
    output req_valid, src1, src2, src1_signed, src2_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_product
  );

  modport slave (
    input  req_valid, src1, src2, src1_signed, src2_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_product
  );
endinterface

// File: rtl/mul_cell_share_ctrl.sv
// Round-robin sequencer sharing one 16x16 four-partial-product multiplier cell between two
// requesters; recombines the cell's partial products into a 64-bit product per request.
module mul_cell_share_ctrl (
  input  logic                         clk,
  input  logic                         reset,
  mul_cell_share_ctrl_if.slave         a_if,
  mul_cell_share_ctrl_if.slave         b_if,
  output logic [31:0]                  cell_src1,
  output logic [31:0]                  cell_src2,
  output logic                         cell_src1_signed,
  output logic                         cell_src2_signed,
  output logic                         cell_en,
  input  logic [31:0]                  cell_p1,
  input  logic [31:0]                  cell_p2,
  input  logic [31:0]                  cell_p3,
  input  logic [31:0]                  cell_p4,
  output logic                         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUM  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;        // 0: A has priority, 1: B has priority
  logic        gnt_q, gnt_d;        // 0: A granted, 1: B granted
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic        s1s_q, s1s_d;
  logic        s2s_q, s2s_d;
  logic [63:0] product_q, product_d;

  logic        idle_s;
  logic        grant_a_s;
  logic        grant_b_s;
  logic        rsp_ready_s;
  logic [63:0] sum_s;

  function automatic logic [63:0] ext32(input logic [31:0] v, input logic sgn);
    ext32 = sgn ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  // Arbitration and recombination terms shared by next-state and datapath logic
  always_comb begin
    idle_s      = (state_q == S_IDLE);
    grant_a_s   = idle_s & a_if.req_valid & (~b_if.req_valid | ~ptr_q);
    grant_b_s   = idle_s & b_if.req_valid & (~a_if.req_valid | ptr_q);
    rsp_ready_s = gnt_q ? b_if.rsp_ready : a_if.rsp_ready;
    sum_s       = {32'd0, cell_p1}
                + (ext32(cell_p2, s2s_q) << 6'd16)
                + (ext32(cell_p3, s1s_q) << 6'd16)
                + (ext32(cell_p4, s1s_q | s2s_q) << 6'd32);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      src1_q    <= 32'd0;
      src2_q    <= 32'd0;
      s1s_q     <= 1'b0;
      s2s_q     <= 1'b0;
      product_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      s1s_q     <= s1s_d;
      s2s_q     <= s2s_d;
      product_q <= product_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a_s | grant_b_s) state_d = S_MUL;
        else                       state_d = S_IDLE;
      end
      S_MUL:  state_d = S_SUM;
      S_SUM:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready_s) state_d = S_IDLE;
        else             state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on grant, priority rotation and product registration
  always_comb begin
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    s1s_d     = s1s_q;
    s2s_d     = s2s_q;
    product_d = product_q;
    if (grant_a_s) begin
      gnt_d  = 1'b0;
      ptr_d  = 1'b1;
      src1_d = a_if.src1;
      src2_d = a_if.src2;
      s1s_d  = a_if.src1_signed;
      s2s_d  = a_if.src2_signed;
    end else if (grant_b_s) begin
      gnt_d  = 1'b1;
      ptr_d  = 1'b0;
      src1_d = b_if.src1;
      src2_d = b_if.src2;
      s1s_d  = b_if.src1_signed;
      s2s_d  = b_if.src2_signed;
    end else begin
      gnt_d = gnt_q;
    end
    if (state_q == S_SUM) product_d = sum_s;
    else                  product_d = product_q;
  end

  // Outputs decoded from state and latched registers
  always_comb begin
    a_if.req_ready   = grant_a_s;
    b_if.req_ready   = grant_b_s;
    a_if.rsp_valid   = (state_q == S_RESP) & ~gnt_q;
    b_if.rsp_valid   = (state_q == S_RESP) &  gnt_q;
    a_if.rsp_product = product_q;
    b_if.rsp_product = product_q;
    cell_src1        = src1_q;
    cell_src2        = src2_q;
    cell_src1_signed = s1s_q;
    cell_src2_signed = s2s_q;
    cell_en          = (state_q == S_MUL);
    busy             = ~idle_s;
  end

endmodule

// File: tb/tb_mul_cell_share_ctrl.sv
// Directed bench for mul_cell_share_ctrl with a behavioural multiplier cell and a
// queue-based scoreboard checked by an independent response monitor.
module tb_mul_cell_share_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_cell_share_ctrl_if a_if ();
  mul_cell_share_ctrl_if b_if ();

  logic [31:0] cell_src1, cell_src2, cell_p1, cell_p2, cell_p3, cell_p4;
  logic        cell_src1_signed, cell_src2_signed, cell_en, busy;

  mul_cell_share_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .a_if             (a_if),
    .b_if             (b_if),
    .cell_src1        (cell_src1),
    .cell_src2        (cell_src2),
    .cell_src1_signed (cell_src1_signed),
    .cell_src2_signed (cell_src2_signed),
    .cell_en          (cell_en),
    .cell_p1          (cell_p1),
    .cell_p2          (cell_p2),
    .cell_p3          (cell_p3),
    .cell_p4          (cell_p4),
    .busy             (busy)
  );

  // 17-bit signed slice product, truncated to the 32-bit cell output
  function automatic logic [31:0] smul(input logic [16:0] x, input logic [16:0] y);
    logic signed [33:0] r;
    r = $signed(x) * $signed(y);
    return r[31:0];
  endfunction

  // Behavioural cell: partial products registered one cycle after cell_en
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_p1 <= 32'd0; cell_p2 <= 32'd0; cell_p3 <= 32'd0; cell_p4 <= 32'd0;
    end else if (cell_en) begin
      cell_p1 <= smul({1'b0, cell_src1[15:0]}, {1'b0, cell_src2[15:0]});
      cell_p2 <= smul({1'b0, cell_src1[15:0]}, {cell_src2_signed & cell_src2[31], cell_src2[31:16]});
      cell_p3 <= smul({cell_src1_signed & cell_src1[31], cell_src1[31:16]}, {1'b0, cell_src2[15:0]});
      cell_p4 <= smul({cell_src1_signed & cell_src1[31], cell_src1[31:16]},
                      {cell_src2_signed & cell_src2[31], cell_src2[31:16]});
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [63:0] exp_a[$], exp_b[$];
  int gc_a[$], gc_b[$];
  int gch_log[$], gcy_log[$];
  logic pa = 1'b0, pb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Response monitor: latency on rising valid, product on each handshake
  always @(negedge clk) begin
    if (a_if.rsp_valid && b_if.rsp_valid) begin
      n_fail++; $display("FAIL both_rsp_valid: got 1 1 expected at most one");
    end
    if (a_if.rsp_valid && !pa) begin
      if (gc_a.size() == 0) begin n_fail++; $display("FAIL a_unexpected_rsp: got valid expected none"); end
      else chk("a_latency", cyc - gc_a.pop_front(), 64'd3);
    end
    if (b_if.rsp_valid && !pb) begin
      if (gc_b.size() == 0) begin n_fail++; $display("FAIL b_unexpected_rsp: got valid expected none"); end
      else chk("b_latency", cyc - gc_b.pop_front(), 64'd3);
    end
    if (a_if.rsp_valid && a_if.rsp_ready && exp_a.size() != 0) chk("a_product", a_if.rsp_product, exp_a.pop_front());
    if (b_if.rsp_valid && b_if.rsp_ready && exp_b.size() != 0) chk("b_product", b_if.rsp_product, exp_b.pop_front());
    pa <= a_if.rsp_valid;
    pb <= b_if.rsp_valid;
  end

  task automatic drive(input bit ch, input bit v, input logic [31:0] x, input logic [31:0] y,
                       input bit sx, input bit sy);
    if (ch == 1'b0) begin
      a_if.req_valid = v; a_if.src1 = x; a_if.src2 = y; a_if.src1_signed = sx; a_if.src2_signed = sy;
    end else begin
      b_if.req_valid = v; b_if.src1 = x; b_if.src2 = y; b_if.src1_signed = sx; b_if.src2_signed = sy;
    end
  endtask

  task automatic issue(input bit ch, input logic [31:0] x, input logic [31:0] y, input bit sx,
                       input bit sy, input logic [63:0] exp, input bit expect_rsp);
    bit got = 1'b0;
    @(posedge clk); #1;
    drive(ch, 1'b1, x, y, sx, sy);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if ((ch == 1'b0 && a_if.req_ready) || (ch == 1'b1 && b_if.req_ready)) begin
        got = 1'b1;
        gch_log.push_back(int'(ch));
        gcy_log.push_back(cyc);
        if (expect_rsp) begin
          if (ch == 1'b0) begin exp_a.push_back(exp); gc_a.push_back(cyc); end
          else            begin exp_b.push_back(exp); gc_b.push_back(cyc); end
        end
      end
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL grant_timeout: got no grant expected grant on ch %0d", ch); end
    @(posedge clk); #1;
    drive(ch, 1'b0, x, y, sx, sy);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) begin n_tests++; n_fail++; $display("FAIL idle_timeout: got busy expected idle"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    bit seen;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    a_if.rsp_ready = 1'b1;
    b_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 64'd0);
    chk("rst_cell_en", cell_en, 64'd0);
    chk("rst_a_rsp_valid", a_if.rsp_valid, 64'd0);
    chk("rst_b_rsp_valid", b_if.rsp_valid, 64'd0);
    chk("rst_product", a_if.rsp_product, 64'd0);
    chk("rst_cell_src1", cell_src1, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
    chk("mul_cell_en", cell_en, 64'd1);
    chk("mul_cell_src1", cell_src1, 64'hFFFFFFFF);
    chk("mul_busy", busy, 64'd1);
    wait_idle();
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001, 1'b1);
    wait_idle();
    issue(1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 1'b1);
    wait_idle();
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001, 1'b1);
    wait_idle();
    issue(1'b0, 32'h00010000, 32'hFFFFFFFE, 1'b0, 1'b1, 64'hFFFFFFFFFFFE0000, 1'b1);
    wait_idle();

    // Both requesters contend from a fresh reset: pointer starts at A
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    gch_log.delete();
    gcy_log.delete();
    fork
      begin
        issue(1'b0, 32'd2, 32'd3, 1'b0, 1'b0, 64'd6, 1'b1);
        issue(1'b0, 32'd7, 32'd9, 1'b0, 1'b0, 64'd63, 1'b1);
        issue(1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h0000000100000000, 1'b1);
      end
      begin
        issue(1'b1, 32'd100, 32'd100, 1'b0, 1'b0, 64'd10000, 1'b1);
        issue(1'b1, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h00000004FFFFFFFB, 1'b1);
      end
    join
    wait_idle();
    chk("grant_count", gch_log.size(), 64'd5);
    for (int i = 0; i < gch_log.size(); i++) chk("grant_order", gch_log[i], i % 2);
    for (int i = 1; i < gcy_log.size(); i++) chk("grant_spacing", gcy_log[i] - gcy_log[i-1], 64'd4);

    // Backpressure on A while B waits
    a_if.rsp_ready = 1'b0;
    issue(1'b0, 32'h12345678, 32'h00000010, 1'b0, 1'b0, 64'h0000000123456780, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = a_if.rsp_valid;
    end
    chk("bp_rsp_seen", seen, 64'd1);
    held = a_if.rsp_product;
    drive(1'b1, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", a_if.rsp_valid, 64'd1);
      chk("bp_stable", a_if.rsp_product, held);
      chk("bp_cell_en", cell_en, 64'd0);
      chk("bp_no_grant", b_if.req_ready, 64'd0);
    end
    @(posedge clk); #1;
    a_if.rsp_ready = 1'b1;
    issue(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 64'd1, 1'b1);
    wait_idle();

    // Reset during SUM discards the operation
    issue(1'b0, 32'd7, 32'd7, 1'b0, 1'b0, 64'd49, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 64'd0);
    chk("abort_cell_en", cell_en, 64'd0);
    chk("abort_rsp_valid", a_if.rsp_valid, 64'd0);
    chk("abort_product", a_if.rsp_product, 64'd0);
    chk("abort_cell_src1", cell_src1, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_idle", busy, 64'd0);
    issue(1'b0, 32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queues_drained", exp_a.size() + exp_b.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_cell_share_ctrl.md
# mul_cell_share_ctrl

Sequencer and round-robin arbiter that shares one four-partial-product 16x16 multiplier cell array between two requesters. It accepts 32x32 multiply requests with per-operand signedness and drives the cell's operand, sign and enable inputs. It recombines the four registered 32-bit partial products into a 64-bit product and returns that product to the granted requester over a valid/ready response channel. The block sits between two 32-bit datapath clients (for example, a CPU execute stage and a custom-instruction unit) and the shared multiplier cell.

## Interface
- No parameters. Operand width 32, cell slice 16, product 64 are fixed.
- clk  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req_valid  in  1  requester A has an operation pending.
- a_req_ready  out  1  A request accepted this cycle.
- a_src1, a_src2  in  32 each  A operands.
- a_src1_signed, a_src2_signed  in  1 each  A operand signedness.
- a_rsp_valid  out  1  A product available.
- a_rsp_ready  in  1  A consumes the product.
- b_* ports  identical set for requester B.
- rsp_product  out  64  product; shared by both response channels and qualified by *_rsp_valid.
- cell_src1, cell_src2  out  32 each  operands to the cell.
- cell_src1_signed, cell_src2_signed  out  1 each  sign controls to the cell.
- cell_en  out  1  cell pipeline-register enable.
- cell_p1..cell_p4  in  32 each  registered partial products. Meaning: p1=lo1*lo2, p2=lo1*hi2, p3=hi1*lo2, p4=hi1*hi2. The cell produces these one cycle after cell_en.
- busy  out  1  the FSM is not IDLE.

## Operation
- FSM states: IDLE, MUL, SUM, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, grant one requester. Its req_ready is high combinationally in this cycle; the other requester's req_ready is low.
  - On grant, latch the operands, sign bits and grant id. Next state is MUL.
- req_ready is low in every state other than IDLE.
- Arbitration:
  - With one request valid, that requester is granted.
  - With both valid, the requester at the priority pointer is granted. The pointer resets to A.
  - After every grant the pointer moves to the non-granted requester.
- MUL:
  - cell_en=1; the cell inputs are driven from the latched registers.
  - Next state is SUM.
  - In all other states cell_en=0. The cell inputs always reflect the latched registers.
- SUM:
  - Register the recombined product as product = P1 + (X2<<16) + (X3<<16) + (X4<<32), modulo 2^64.
  - X2 = cell_p2 sign-extended to 64 bits if src2_signed, otherwise zero-extended.
  - X3 = cell_p3 sign-extended if src1_signed, otherwise zero-extended.
  - X4 = cell_p4 sign-extended if src1_signed or src2_signed, otherwise zero-extended.
  - P1 = cell_p1 always zero-extended.
  - Next state is RESP.
- RESP:
  - The granted requester's rsp_valid=1 and rsp_product holds stable.
  - On rsp_ready the FSM goes to IDLE. rsp_valid stays high until then (unbounded backpressure).
- The non-granted rsp_valid is always 0. A requester's response is never visible on the other channel.
- Reset values: all req_ready/rsp_valid=0, cell_en=0, busy=0, rsp_product=0, latched operands and signs=0, priority pointer=A.
- Reset asserted mid-operation aborts the operation: the FSM returns to IDLE and the in-flight result is discarded without any response.
- A requester dropping req_valid before being granted is legal. Once granted, its operands are already captured.

## Timing
- Grant in cycle T (valid & ready).
- cell_en=1 in T+1.
- Partial products are valid in T+2; the product is registered at the end of T+2.
- rsp_valid rises in T+3. With rsp_ready held high, the response completes in T+3 and IDLE is reached in T+4.
- Minimum spacing between grants is 4 cycles. Response latency from grant is 3 cycles.
- The cell is clocked by clk with its clear driven from the same reset. No cell_en pulse occurs during or immediately after reset.

## Test plan
- A only, unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> a_rsp_valid at T+3 with 0xFFFFFFFE00000001; b_rsp_valid stays 0.
- B only, both signed, 0xFFFFFFFF x 0xFFFFFFFF -> 0x0000000000000001. Also 0x80000000 x 0x80000000 both signed -> 0x4000000000000000.
- Mixed signedness: src1 signed 0xFFFFFFFF x unsigned 0xFFFFFFFF -> 0xFFFFFFFF00000001. Also src1 unsigned 0x00010000 x signed 0xFFFFFFFE -> 0xFFFFFFFFFFFE0000.
- A and B both valid continuously after reset -> grants alternate A, B, A, B. Each response carries its own operands' product. Grants are 4 cycles apart.
- Backpressure: hold a_rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_product stay stable, no new grant occurs and cell_en stays 0. Releasing rsp_ready completes the response.
- Reset asserted in SUM -> all outputs return to reset values immediately and no response is issued. After release, a new A request of 3 x 5 returns 15.
